const_fetch: RTL and testbench

Controller that fetches one GF(3^m) constant from the constant ROM on request and hands it to the datapath. It sits directly upstream of the ROM. It converts a compact 3-bit constant index into the ROM's one-hot address and sequences the ROM's one-cycle registered latency. It captures the ROM word, optionally negates it over GF(3), and flags indices the ROM does not hold. Consumers see a single `done` pulse with the word held stable on `data` until the next capture.

---
 rtl/const_fetch.sv | 105 ++++++++++
 tb/tb_const_fetch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/const_fetch.sv
// Constant-ROM fetch controller: decodes a 3-bit constant index to a one-hot ROM
// address, waits out the ROM's registered latency, and presents the word (optionally GF(3)-negated).
module const_fetch #(
  parameter int WIDTH = 198,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [2:0]       sel,
  input  logic             neg,
  output logic             busy,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_out,
  input  logic             rom_eff,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             neg_q, neg_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] neg_word;
  logic             accept;

  // GF(3) negation per 2-bit coefficient is a swap of its two bits (1 <-> 2, 0 stays 0).
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    neg_word = '0;
    for (int k = 0; k < WIDTH / 2; k++) begin
      neg_word[2*k]   = rom_out[2*k+1];
      neg_word[2*k+1] = rom_out[2*k];
    end
  end

  always_comb begin
    accept  = req & ((state_q == S_IDLE) | (state_q == S_DONE));
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_DONE;
      S_DONE:  state_d = accept ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    sel_d = accept ? sel : sel_q;
    neg_d = accept ? neg : neg_q;

    // Indices 5..7 decode to no address; the ROM's ineffective default raises err.
    rom_addr_d = '0;
    if ((state_d == S_ISSUE) && (sel_d <= 3'd4)) rom_addr_d = AW'(1) << sel_d;

    busy_d = (state_d == S_ISSUE) | (state_d == S_WAIT);
    done_d = (state_q == S_WAIT);

    data_d = data_q;
    err_d  = err_q;
    if (state_q == S_WAIT) begin
      err_d  = ~rom_eff;
      data_d = rom_eff ? (neg_q ? neg_word : rom_out) : '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      neg_q      <= 1'b0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      neg_q      <= neg_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      data_q     <= data_d;
    end
  end

  assign busy     = busy_q;
  assign rom_addr = rom_addr_q;
  assign done     = done_q;
  assign err      = err_q;
  assign data     = data_q;

endmodule

// File: tb/tb_const_fetch.sv
// Directed bench for const_fetch with a registered one-hot constant ROM model.
module tb_const_fetch;

  localparam int WIDTH = 198;
  localparam int AW    = 7;

  localparam logic [WIDTH-1:0] C_ZERO  = '0;
  localparam logic [WIDTH-1:0] C_ONE   = 198'd1;
  localparam logic [WIDTH-1:0] C_PLUS  = {6'b000101, 192'd0};
  localparam logic [WIDTH-1:0] C_MINUS = {6'b001001, 192'd0};
  localparam logic [WIDTH-1:0] C_CUBIC = {6'b010101, 192'd0};

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req;
  logic [2:0]       sel;
  logic             neg;
  logic             busy;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_out;
  logic             rom_eff;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] data;

  int n_tests = 0;
  int n_fail  = 0;

  const_fetch #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .sel      (sel),
    .neg      (neg),
    .busy     (busy),
    .rom_addr (rom_addr),
    .rom_out  (rom_out),
    .rom_eff  (rom_eff),
    .done     (done),
    .err      (err),
    .data     (data)
  );

  always #5 clk = ~clk;

  // One-cycle registered ROM; anything but a populated one-hot address reads as zero/ineffective.
  always @(posedge clk) begin
    case (rom_addr)
      7'b0000001: begin rom_out <= C_ZERO;  rom_eff <= 1'b1; end
      7'b0000010: begin rom_out <= C_ONE;   rom_eff <= 1'b1; end
      7'b0000100: begin rom_out <= C_PLUS;  rom_eff <= 1'b1; end
      7'b0001000: begin rom_out <= C_MINUS; rom_eff <= 1'b1; end
      7'b0010000: begin rom_out <= C_CUBIC; rom_eff <= 1'b1; end
      default:    begin rom_out <= C_ZERO;  rom_eff <= 1'b0; end
    endcase
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single fetch from IDLE: ISSUE, WAIT, DONE, then back to IDLE with results held.
  task automatic fetch(input string tag, input logic [2:0] s, input logic n,
                       input logic [AW-1:0] exp_addr, input logic [WIDTH-1:0] exp_data,
                       input logic exp_err);
    req = 1'b1; sel = s; neg = n;
    step();
    req = 1'b0; sel = 3'd0; neg = 1'b0;
    check({tag, ".issue_addr"}, WIDTH'(rom_addr), WIDTH'(exp_addr));
    check({tag, ".issue_busy"}, WIDTH'(busy), WIDTH'(1'b1));
    check({tag, ".issue_done"}, WIDTH'(done), WIDTH'(1'b0));
    step();
    check({tag, ".wait_busy"}, WIDTH'(busy), WIDTH'(1'b1));
    check({tag, ".wait_addr"}, WIDTH'(rom_addr), '0);
    check({tag, ".wait_done"}, WIDTH'(done), WIDTH'(1'b0));
    step();
    check({tag, ".done"}, WIDTH'(done), WIDTH'(1'b1));
    check({tag, ".done_busy"}, WIDTH'(busy), WIDTH'(1'b0));
    check({tag, ".data"}, data, exp_data);
    check({tag, ".err"}, WIDTH'(err), WIDTH'(exp_err));
    step();
    check({tag, ".done_low"}, WIDTH'(done), WIDTH'(1'b0));
    check({tag, ".data_held"}, data, exp_data);
    check({tag, ".err_held"}, WIDTH'(err), WIDTH'(exp_err));
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; sel = 3'd0; neg = 1'b0;
    step();
    step();
    check("rst.busy", WIDTH'(busy), '0);
    check("rst.done", WIDTH'(done), '0);
    check("rst.err", WIDTH'(err), '0);
    check("rst.data", data, '0);
    check("rst.addr", WIDTH'(rom_addr), '0);
    reset_n = 1'b1;
    step();

    fetch("one",       3'd1, 1'b0, 7'b0000010, C_ONE, 1'b0);
    fetch("plus",      3'd2, 1'b0, 7'b0000100, {6'b000101, 192'd0}, 1'b0);
    fetch("plus_neg",  3'd2, 1'b1, 7'b0000100, {6'b001010, 192'd0}, 1'b0);
    fetch("minus_neg", 3'd3, 1'b1, 7'b0001000, {6'b000110, 192'd0}, 1'b0);
    fetch("cubic",     3'd4, 1'b0, 7'b0010000, {6'b010101, 192'd0}, 1'b0);
    fetch("one_neg",   3'd1, 1'b1, 7'b0000010, 198'd2, 1'b0);
    fetch("inv6",      3'd6, 1'b0, 7'b0000000, '0, 1'b1);
    fetch("zero",      3'd0, 1'b0, 7'b0000001, '0, 1'b0);
    fetch("inv7",      3'd7, 1'b1, 7'b0000000, '0, 1'b1);
    fetch("clr_err",   3'd4, 1'b1, 7'b0010000, {6'b101010, 192'd0}, 1'b0);

    // A req pulse during ISSUE must not start another fetch.
    req = 1'b1; sel = 3'd2; neg = 1'b0;
    step();
    sel = 3'd3; neg = 1'b1;
    step();
    req = 1'b0;
    check("pulse.wait_addr", WIDTH'(rom_addr), '0);
    step();
    check("pulse.done", WIDTH'(done), WIDTH'(1'b1));
    check("pulse.data", data, C_PLUS);
    step();
    check("pulse.idle_busy", WIDTH'(busy), '0);
    check("pulse.idle_addr", WIDTH'(rom_addr), '0);
    check("pulse.idle_done", WIDTH'(done), '0);

    // req held throughout: sel=1 accepted from IDLE, sel=4 accepted in the DONE cycle.
    req = 1'b1; sel = 3'd1; neg = 1'b0;
    step();
    check("b2b.addr1", WIDTH'(rom_addr), WIDTH'(7'b0000010));
    sel = 3'd4;
    step();
    check("b2b.wait1_busy", WIDTH'(busy), WIDTH'(1'b1));
    step();
    check("b2b.done1", WIDTH'(done), WIDTH'(1'b1));
    check("b2b.data1", data, C_ONE);
    step();
    req = 1'b0;
    check("b2b.addr2", WIDTH'(rom_addr), WIDTH'(7'b0010000));
    check("b2b.gap1", WIDTH'(done), '0);
    check("b2b.busy2", WIDTH'(busy), WIDTH'(1'b1));
    check("b2b.data1_held", data, C_ONE);
    step();
    check("b2b.gap2", WIDTH'(done), '0);
    step();
    check("b2b.done2", WIDTH'(done), WIDTH'(1'b1));
    check("b2b.data2", data, C_CUBIC);
    step();
    check("b2b.end_busy", WIDTH'(busy), '0);

    // Reset in WAIT aborts the fetch; everything reads zero afterwards.
    req = 1'b1; sel = 3'd2; neg = 1'b0;
    step();
    req = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("abort.busy", WIDTH'(busy), '0);
    check("abort.done", WIDTH'(done), '0);
    check("abort.err", WIDTH'(err), '0);
    check("abort.data", data, '0);
    check("abort.addr", WIDTH'(rom_addr), '0);
    step();
    check("abort.no_done", WIDTH'(done), '0);
    step();
    check("abort.still_no_done", WIDTH'(done), '0);
    fetch("after_abort", 3'd3, 1'b0, 7'b0001000, C_MINUS, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
